// File: rtl/encoder_4x2_seq_pkg.sv
// Shared definitions for the 4-line sticky request encoder.
package encoder_4x2_seq_pkg;

  localparam int CODE_W = 2;
  localparam int NLINES = 1 << CODE_W;

  // Selection policies for the RR parameter
  localparam int RR_FIXED = 0;
  localparam int RR_ROUND = 1;

  typedef enum logic {
    ST_IDLE    = 1'b0,
    ST_PRESENT = 1'b1
  } state_t;

endpackage

// File: rtl/encoder_4x2_pick.sv
// Combinational line selector: fixed priority (highest index) or
// round-robin search upward from ptr, wrapping modulo the line count.
module encoder_4x2_pick
  import encoder_4x2_seq_pkg::*;
(
  input  logic [NLINES-1:0] req,
  input  logic [CODE_W-1:0] ptr,
  input  logic              rr,
  output logic [CODE_W-1:0] idx,
  output logic              any
);

  logic [CODE_W-1:0] w_j;

  // Select one requesting line; later loop iterations override earlier ones
  always_comb begin
    idx = '0;
    w_j = '0;
    any = |req;
    if (!rr) begin
      // Ascending scan so the highest set index is the one kept
      for (int i = 0; i < NLINES; i++) begin
        if (req[i]) idx = CODE_W'(i);
      end
    end else begin
      // Descending offset scan so the smallest offset from ptr is kept
      for (int k = NLINES - 1; k >= 0; k--) begin
        w_j = ptr + CODE_W'(k);
        if (req[w_j]) idx = w_j;
      end
    end
  end

endmodule

// File: rtl/encoder_4x2_seq.sv
// Sticky 4-line request collector presenting one pending line index at a
// time on a valid/ready handshake; the accepted line is cleared.
module encoder_4x2_seq
  import encoder_4x2_seq_pkg::*;
#(
  parameter int RR = 0,
  parameter int W  = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NLINES-1:0] a,
  input  logic              ready,
  output logic [W-1:0]      b,
  output logic              valid,
  output logic [NLINES-1:0] pending,
  output logic              overflow
);

  state_t            r_state;
  state_t            w_state_nx;
  logic              w_load;
  logic [W-1:0]      r_b;
  logic [W-1:0]      r_ptr;
  logic [W-1:0]      w_ptr_nx;
  logic [NLINES-1:0] r_pending;
  logic              r_overflow;
  logic              w_acc;
  logic [NLINES-1:0] w_clr;
  logic [NLINES-1:0] w_pending_nx;
  logic              w_overflow_nx;
  logic [W-1:0]      w_pick;
  logic              w_any;
  logic              w_rr;

  assign w_rr = (RR != RR_FIXED);

  // Accept, clear mask, and the next pending set (new events win over clear)
  always_comb begin
    w_acc         = valid & ready;
    w_clr         = w_acc ? (NLINES'(1) << r_b) : '0;
    w_pending_nx  = (r_pending & ~w_clr) | a;
    w_overflow_nx = |(a & r_pending & ~w_clr);
    // Search from the pointer as it will stand after this cycle's accept,
    // so the just-served line goes to the back of the rotation
    w_ptr_nx      = w_acc ? (r_b + W'(1)) : r_ptr;
  end

  encoder_4x2_pick u_pick (
    .req (w_pending_nx),
    .ptr (w_ptr_nx),
    .rr  (w_rr),
    .idx (w_pick),
    .any (w_any)
  );

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_state_nx;
  end

  // Next state and code-load decision; a stalled code is never replaced
  always_comb begin
    w_state_nx = r_state;
    w_load     = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_any) begin
          w_state_nx = ST_PRESENT;
          w_load     = 1'b1;
        end
      end
      ST_PRESENT: begin
        if (ready) begin
          if (w_any) w_load     = 1'b1;
          else       w_state_nx = ST_IDLE;
        end
      end
      default: w_state_nx = ST_IDLE;
    endcase
  end

  // FSM outputs
  always_comb begin
    valid = (r_state == ST_PRESENT);
  end

  // Datapath registers: presented code, pointer, pending set, overflow pulse
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_b        <= '0;
      r_ptr      <= '0;
      r_pending  <= '0;
      r_overflow <= 1'b0;
    end else begin
      if (w_load) r_b <= w_pick;
      r_ptr      <= w_ptr_nx;
      r_pending  <= w_pending_nx;
      r_overflow <= w_overflow_nx;
    end
  end

  assign b        = r_b;
  assign pending  = r_pending;
  assign overflow = r_overflow;

endmodule
